// File: rtl/tmds_pll_seq_if.sv
// rtl/tmds_pll_seq_if.sv - Lock input, mode-request handshake and PLL control outputs of tmds_pll_seq
interface tmds_pll_seq_if;
    logic       I_lock;
    logic       I_mode_req;
    logic [1:0] I_mode;
    logic       O_mode_ack;
    logic       O_pll_rst;
    logic [6:0] O_mdiv;
    logic [6:0] O_odiv0;
    logic [6:0] O_odiv1;
    logic [1:0] O_cur_mode;
    logic       O_pix_rst_n;
    logic       O_busy;
    logic       O_fail;

    modport slave (
        input  I_lock, I_mode_req, I_mode,
        output O_mode_ack, O_pll_rst, O_mdiv, O_odiv0, O_odiv1,
        output O_cur_mode, O_pix_rst_n, O_busy, O_fail
    );

    modport master (
        output I_lock, I_mode_req, I_mode,
        input  O_mode_ack, O_pll_rst, O_mdiv, O_odiv0, O_odiv1,
        input  O_cur_mode, O_pix_rst_n, O_busy, O_fail
    );
endinterface

// File: rtl/tmds_pll_seq.sv
// rtl/tmds_pll_seq.sv - TMDS PLL reset/lock sequencer with video-mode divider control
module tmds_pll_seq #(
    parameter int RST_CYCLES   = 32,
    parameter int LOCK_STABLE  = 4096,
    parameter int LOCK_TIMEOUT = 500000,
    parameter int MAX_RETRY    = 3,
    parameter int DEFAULT_MODE = 1
) (
    input  logic          I_clk,
    input  logic          I_rst_n,
    tmds_pll_seq_if.slave bus
);
    localparam int MAX_AB  = (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
    localparam int MAX_CNT = (MAX_AB > LOCK_TIMEOUT) ? MAX_AB : LOCK_TIMEOUT;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam logic [1:0] DEF_MODE = 2'(DEFAULT_MODE);

    typedef enum logic [2:0] {RST_PLL, WAIT_LOCK, STABLE, RUN, FAIL} state_t;

    // {MDIV, ODIV0, ODIV1} per video mode
    function automatic logic [20:0] mode_divs(input logic [1:0] m);
        logic [20:0] d;
        case (m)
            2'd0:    d = {7'd20, 7'd8, 7'd40};
            2'd1:    d = {7'd16, 7'd4, 7'd20};
            2'd2:    d = {7'd15, 7'd2, 7'd10};
            default: d = {7'd13, 7'd2, 7'd10};
        endcase
        return d;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d;
    logic [1:0]       cur_mode_q, cur_mode_d;
    logic [20:0]      divs_q, divs_d;
    logic             ack_q, ack_d;
    logic             pll_rst_q, pix_rst_n_q, busy_q, fail_q;
    logic             lock_meta_q, lock_s_q;
    logic             accept;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        retry_d    = retry_q;
        cur_mode_d = cur_mode_q;
        divs_d     = divs_q;
        ack_d      = 1'b0;
        accept     = ((state_q == RUN) || (state_q == FAIL)) && bus.I_mode_req && !ack_q;

        case (state_q)
            RST_PLL: begin
                if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_LOCK: begin
                // the cycle that first sees lock counts toward the stable window
                if (lock_s_q) begin
                    if (LOCK_STABLE <= 1) begin
                        state_d = RUN;
                        retry_d = '0;
                        cnt_d   = '0;
                    end else begin
                        state_d = STABLE;
                        cnt_d   = CNT_W'(1);
                    end
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    retry_d = retry_q + 4'd1;
                    cnt_d   = '0;
                    state_d = (retry_q + 4'd1 == 4'(MAX_RETRY)) ? FAIL : RST_PLL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STABLE: begin
                if (!lock_s_q) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(LOCK_STABLE - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (!lock_s_q) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            FAIL:    state_d = FAIL;
            default: state_d = RST_PLL;
        endcase

        // an accepted request overrides lock loss; same-mode requests in a locked RUN skip the relock
        if (accept) begin
            ack_d      = 1'b1;
            cur_mode_d = bus.I_mode;
            retry_d    = '0;
            divs_d     = mode_divs(bus.I_mode);
            if (!((state_q == RUN) && (bus.I_mode == cur_mode_q) && lock_s_q)) begin
                state_d = RST_PLL;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            state_q     <= RST_PLL;
            cnt_q       <= '0;
            retry_q     <= '0;
            cur_mode_q  <= DEF_MODE;
            divs_q      <= mode_divs(DEF_MODE);
            ack_q       <= 1'b0;
            pll_rst_q   <= 1'b1;
            pix_rst_n_q <= 1'b0;
            busy_q      <= 1'b1;
            fail_q      <= 1'b0;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            cur_mode_q  <= cur_mode_d;
            divs_q      <= divs_d;
            ack_q       <= ack_d;
            pll_rst_q   <= (state_d == RST_PLL) || (state_d == FAIL);
            pix_rst_n_q <= (state_d == RUN);
            busy_q      <= (state_d != RUN);
            fail_q      <= (state_d == FAIL);
            lock_meta_q <= bus.I_lock;
            lock_s_q    <= lock_meta_q;
        end
    end

    assign bus.O_mode_ack  = ack_q;
    assign bus.O_pll_rst   = pll_rst_q;
    assign bus.O_mdiv      = divs_q[20:14];
    assign bus.O_odiv0     = divs_q[13:7];
    assign bus.O_odiv1     = divs_q[6:0];
    assign bus.O_cur_mode  = cur_mode_q;
    assign bus.O_pix_rst_n = pix_rst_n_q;
    assign bus.O_busy      = busy_q;
    assign bus.O_fail      = fail_q;
endmodule

// File: tb/tb_tmds_pll_seq.sv
// tb/tb_tmds_pll_seq.sv - Self-checking bench for tmds_pll_seq: directed sequences, mode table vectors, random run vs model
module tb_tmds_pll_seq;
    localparam int RST_C = 4;
    localparam int STAB  = 8;
    localparam int TMO   = 50;
    localparam int MAXR  = 2;

    localparam int P_RST  = 0;
    localparam int P_WAIT = 1;
    localparam int P_STAB = 2;
    localparam int P_RUN  = 3;
    localparam int P_FAIL = 4;

    localparam int TBL_MDIV  [4] = '{20, 16, 15, 13};
    localparam int TBL_ODIV0 [4] = '{8, 4, 2, 2};
    localparam int TBL_ODIV1 [4] = '{40, 20, 10, 10};

    typedef struct {
        logic [1:0] mode;
        logic [6:0] mdiv;
        logic [6:0] odiv0;
        logic [6:0] odiv1;
        bit         relock;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    tmds_pll_seq_if bus();

    tmds_pll_seq #(
        .RST_CYCLES  (RST_C),
        .LOCK_STABLE (STAB),
        .LOCK_TIMEOUT(TMO),
        .MAX_RETRY   (MAXR),
        .DEFAULT_MODE(1)
    ) dut (
        .I_clk  (clk),
        .I_rst_n(rst_n),
        .bus    (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(bit pll, bit pix, bit busy, bit fail, bit ack, logic [1:0] cur);
        return {4'b0, pll, pix, busy, fail, ack, cur,
                7'(TBL_MDIV[cur]), 7'(TBL_ODIV0[cur]), 7'(TBL_ODIV1[cur])};
    endfunction

    function automatic logic [31:0] dut_vec();
        return {4'b0, bus.O_pll_rst, bus.O_pix_rst_n, bus.O_busy, bus.O_fail, bus.O_mode_ack,
                bus.O_cur_mode, bus.O_mdiv, bus.O_odiv0, bus.O_odiv1};
    endfunction

    // Reference model: phase plus entry timestamp, lock seen through a two-deep delay queue
    int         m_phase = P_RST;
    int         m_t0    = 0;
    int         m_cyc   = 0;
    int         m_fails = 0;
    int         m_n;
    int         m_nxt;
    logic [1:0] m_cur   = 2'd1;
    bit         m_ack   = 1'b0;
    bit         m_live  = 1'b0;
    bit         m_ls;
    bit         m_acc;
    bit         hist[$];

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = P_RST;
            m_t0    = 0;
            m_cyc   = 0;
            m_fails = 0;
            m_cur   = 2'd1;
            m_ack   = 1'b0;
            hist.delete();
            hist.push_back(1'b0);
            hist.push_back(1'b0);
            m_live  = 1'b1;
        end else if (m_live) begin
            m_ls = hist.pop_front();
            hist.push_back(bus.I_lock);
            m_n   = m_cyc - m_t0 + 1;
            m_nxt = m_phase;
            m_acc = 1'b0;
            case (m_phase)
                P_RST:  if (m_n == RST_C) m_nxt = P_WAIT;
                P_WAIT: begin
                    if (m_ls) m_nxt = (STAB == 1) ? P_RUN : P_STAB;
                    else if (m_n == TMO) begin
                        m_fails++;
                        m_nxt = (m_fails == MAXR) ? P_FAIL : P_RST;
                    end
                end
                P_STAB: begin
                    if (!m_ls) m_nxt = P_WAIT;
                    else if (m_n + 1 == STAB) m_nxt = P_RUN;
                end
                P_RUN:  if (!m_ls) m_nxt = P_WAIT;
                default: ;
            endcase
            if (m_nxt == P_RUN && m_phase != P_RUN) m_fails = 0;
            if ((m_phase == P_RUN || m_phase == P_FAIL) && bus.I_mode_req && !m_ack) begin
                m_acc   = 1'b1;
                m_fails = 0;
                if (!(m_phase == P_RUN && bus.I_mode == m_cur && m_ls)) m_nxt = P_RST;
                m_cur = bus.I_mode;
            end
            m_ack = m_acc;
            m_cyc++;
            if (m_nxt != m_phase) m_t0 = m_cyc;
            m_phase = m_nxt;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("model_cycle", dut_vec(),
                mk(m_phase == P_RST || m_phase == P_FAIL, m_phase == P_RUN, m_phase != P_RUN,
                   m_phase == P_FAIL, m_ack, m_cur));
        end
    end

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        vec_t vecs [6];
        int   n;
        bit   saw;

        vecs[0] = '{2'd2, 7'd15, 7'd2, 7'd10, 1'b1};
        vecs[1] = '{2'd2, 7'd15, 7'd2, 7'd10, 1'b0};
        vecs[2] = '{2'd3, 7'd13, 7'd2, 7'd10, 1'b1};
        vecs[3] = '{2'd1, 7'd16, 7'd4, 7'd20, 1'b1};
        vecs[4] = '{2'd1, 7'd16, 7'd4, 7'd20, 1'b0};
        vecs[5] = '{2'd0, 7'd20, 7'd8, 7'd40, 1'b1};

        bus.I_lock     = 1'b0;
        bus.I_mode_req = 1'b0;
        bus.I_mode     = 2'd0;
        rst_n          = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", dut_vec(), mk(1, 0, 1, 0, 0, 2'd1));

        // power-up
        rst_n = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (bus.O_pll_rst && n < 100);
        chk("pwrup_pll_rst_cycles", 32'(n), 32'(RST_C));
        repeat (10) @(negedge clk);
        bus.I_lock = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.O_pix_rst_n && n < 100);
        chk("pwrup_pix_latency", 32'(n), 32'(2 + STAB));
        chk("pwrup_divs", {11'b0, bus.O_mdiv, bus.O_odiv0, bus.O_odiv1}, {11'b0, 7'd16, 7'd4, 7'd20});
        chk("pwrup_busy", 32'(bus.O_busy), 32'd0);

        // lock loss in RUN, then a one-cycle glitch while STABLE
        bus.I_lock = 1'b0;
        saw = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; saw |= bus.O_pll_rst; end while (bus.O_pix_rst_n && n < 100);
        chk("loss_pix_fall", 32'(n), 32'd3);
        chk("loss_busy", 32'(bus.O_busy), 32'd1);
        repeat (2) begin @(negedge clk); saw |= bus.O_pll_rst; end
        bus.I_lock = 1'b1;
        repeat (4) begin @(negedge clk); saw |= bus.O_pll_rst; end
        bus.I_lock = 1'b0;
        @(negedge clk);
        saw |= bus.O_pll_rst;
        bus.I_lock = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; saw |= bus.O_pll_rst; end while (!bus.O_pix_rst_n && n < 100);
        chk("glitch_relock", 32'(n), 32'(2 + STAB));
        chk("relock_no_pll_rst", 32'(saw), 32'd0);

        // timeout path into FAIL
        bus.I_lock = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (bus.O_pix_rst_n && n < 100);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.O_pll_rst && n < 200);
        chk("tmo_window1", 32'(n), 32'(TMO));
        n = 0;
        do begin @(negedge clk); n++; end while (bus.O_pll_rst && n < 200);
        chk("tmo_rst_pulse", 32'(n), 32'(RST_C));
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.O_pll_rst && n < 200);
        chk("tmo_window2", 32'(n), 32'(TMO));
        chk("tmo_fail", {30'b0, bus.O_fail, bus.O_pll_rst}, 32'd3);
        repeat (5) @(negedge clk);
        chk("fail_holds", 32'(bus.O_fail), 32'd1);

        // recovery from FAIL with mode 0; retry count must restart from zero
        bus.I_mode     = 2'd0;
        bus.I_mode_req = 1'b1;
        @(negedge clk);
        chk("fail_ack", dut_vec(), mk(1, 0, 1, 0, 1, 2'd0));
        bus.I_mode_req = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.O_fail && n < 400);
        chk("fail_retry_cleared", 32'(n), 32'(2 * (RST_C + TMO)));
        bus.I_lock     = 1'b1;
        bus.I_mode_req = 1'b1;
        @(negedge clk);
        chk("fail_ack2", 32'(bus.O_mode_ack), 32'd1);
        bus.I_mode_req = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.O_pix_rst_n && n < 100);
        chk("fail_recover_run", 32'(n), 32'(RST_C + STAB));

        // mode table vectors, each applied from RUN
        for (int i = 0; i < 6; i++) begin
            bus.I_mode     = vecs[i].mode;
            bus.I_mode_req = 1'b1;
            @(negedge clk);
            chk("mode_ack", 32'(bus.O_mode_ack), 32'd1);
            chk("mode_divs", {11'b0, bus.O_mdiv, bus.O_odiv0, bus.O_odiv1},
                {11'b0, vecs[i].mdiv, vecs[i].odiv0, vecs[i].odiv1});
            chk("mode_cur", 32'(bus.O_cur_mode), 32'(vecs[i].mode));
            chk("mode_pll_rst", 32'(bus.O_pll_rst), 32'(vecs[i].relock));
            bus.I_mode_req = 1'b0;
            @(negedge clk);
            chk("mode_ack_pulse", 32'(bus.O_mode_ack), 32'd0);
            if (vecs[i].relock) begin
                n = 1;
                while (!bus.O_pix_rst_n && n < 100) begin @(negedge clk); n++; end
                chk("mode_relock_time", 32'(n), 32'(RST_C + STAB));
            end else begin
                chk("mode_same_pix", 32'(bus.O_pix_rst_n), 32'd1);
            end
        end

        // lock loss and request in the same RUN cycle
        bus.I_lock = 1'b0;
        repeat (2) @(negedge clk);
        bus.I_mode     = 2'd2;
        bus.I_mode_req = 1'b1;
        @(negedge clk);
        chk("simul_ack", dut_vec(), mk(1, 0, 1, 0, 1, 2'd2));
        bus.I_mode_req = 1'b0;
        bus.I_lock     = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.O_pix_rst_n && n < 100);
        chk("simul_relock", 32'(bus.O_pix_rst_n), 32'd1);

        // reset in the middle of WAIT_LOCK
        bus.I_lock = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (bus.O_pix_rst_n && n < 100);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_outputs", dut_vec(), mk(1, 0, 1, 0, 0, 2'd1));
        @(negedge clk);
        rst_n = 1'b1;

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (bus.O_mode_ack) begin
                bus.I_mode_req = 1'b0;
            end else if (!bus.I_mode_req && $urandom_range(0, 59) == 0) begin
                bus.I_mode_req = 1'b1;
                bus.I_mode     = 2'($urandom_range(0, 3));
            end
            if (bus.I_lock ? ($urandom_range(0, 79) == 0) : ($urandom_range(0, 9) == 0))
                bus.I_lock = ~bus.I_lock;
            rst_n = ($urandom_range(0, 999) != 0);
        end

        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
